// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer control stage: state encoding,
// default timing constants and the counter width helper.
package timer_pkg;

   // Control FSM states; the encoding is fixed so that debug probes and
   // downstream logic can rely on it.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Default clk cycles per count-enable tick (one second at 50 MHz).
   localparam int PRESCALE_DEF = 50_000_000;

   // Default number of stable synchronized cycles before a button change is accepted.
   localparam int DEBOUNCE_DEF = 1_000_000;

   // Bits needed to hold the values 0..value-1, never less than one bit.
   function automatic int clog2w(input int value);
      int result;
      result = 1;
      for (int i = 1; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) begin
            result = i + 1;
         end else begin
            result = result;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioning: two-flop synchronizer, consecutive-cycle debounce
// counter and a one-cycle registered pulse on each accepted press.
module btn_debounce
   import timer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw_i,
   output logic press_o
);

   localparam int              CW       = clog2w(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};

   logic          sync1_q;
   logic          sync2_q;
   logic          level_q;
   logic          level_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          press_q;
   logic          press_d;

   // Debounce decision: count consecutive cycles in which the synchronized level
   // disagrees with the accepted level; any agreeing cycle restarts the count.
   always_comb begin
      level_d = level_q;
      cnt_d   = CNT_ZERO;
      press_d = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = CNT_ZERO;
            // Only a newly accepted high level is a press; releases stay silent.
            press_d = sync2_q;
         end else begin
            cnt_d   = cnt_q + CW'(1'b1);
         end
      end else begin
         cnt_d = CNT_ZERO;
      end
   end

   // Synchronizer, debounce state and registered press pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= CNT_ZERO;
         press_q <= 1'b0;
      end else begin
         sync1_q <= btn_raw_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/timer_ctrl.sv
// Control stage in front of the down-counting digit cascade: debounced
// start/clear buttons, IDLE/RUN/PAUSE/DONE sequencing, a prescaler that
// produces the cascade count enable, and the cascade reload pulse.
module timer_ctrl
   import timer_pkg::*;
#(
   parameter int PRESCALE        = PRESCALE_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_start,
   input  logic btn_clear,
   input  logic tc,
   output logic CE,
   output logic load,
   output logic running,
   output logic done
);

   localparam int            PW       = clog2w(PRESCALE);
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [PW-1:0] PRE_ZERO = {PW{1'b0}};

   logic          start_press_s;
   logic          clear_press_s;
   logic          tick_s;

   state_e        state_q;
   state_e        state_d;
   logic [PW-1:0] pre_q;
   logic [PW-1:0] pre_d;
   logic          ce_q;
   logic          ce_d;
   logic          load_q;
   logic          load_d;
   logic          running_q;
   logic          running_d;
   logic          done_q;
   logic          done_d;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_start_btn (
      .clk       (clk),
      .reset     (reset),
      .btn_raw_i (btn_start),
      .press_o   (start_press_s)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_clear_btn (
      .clk       (clk),
      .reset     (reset),
      .btn_raw_i (btn_clear),
      .press_o   (clear_press_s)
   );

   assign tick_s = (pre_q == PRE_LAST);

   // Next-state logic; clear overrides everything, terminal count beats a pause request.
   always_comb begin
      state_d = state_q;
      if (clear_press_s) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // With the cascade already at zero there is nothing to count.
               if (start_press_s && !tc) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (tc) begin
                  state_d = ST_DONE;
               end else if (start_press_s) begin
                  state_d = ST_PAUSE;
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_PAUSE: begin
               if (start_press_s) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_PAUSE;
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Prescaler: advances only while running, holds through a pause so the partial
   // period survives, and restarts on clear or on a fresh start from IDLE.
   always_comb begin
      pre_d = pre_q;
      if (clear_press_s) begin
         pre_d = PRE_ZERO;
      end else if ((state_q == ST_IDLE) && (state_d == ST_RUN)) begin
         pre_d = PRE_ZERO;
      end else if (state_q == ST_RUN) begin
         if (tick_s) begin
            pre_d = PRE_ZERO;
         end else begin
            pre_d = pre_q + PW'(1'b1);
         end
      end else begin
         pre_d = pre_q;
      end
   end

   // Output decode; running/done follow the next state so they line up with the state register.
   always_comb begin
      ce_d      = (state_q == ST_RUN) && tick_s && !tc;
      load_d    = clear_press_s;
      running_d = (state_d == ST_RUN);
      done_d    = (state_d == ST_DONE);
   end

   // State, prescaler and output registers; load powers up high so the cascade
   // is reloaded on the first edge after reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         pre_q     <= PRE_ZERO;
         ce_q      <= 1'b0;
         load_q    <= 1'b1;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pre_q     <= pre_d;
         ce_q      <= ce_d;
         load_q    <= load_d;
         running_q <= running_d;
         done_q    <= done_d;
      end
   end

   assign CE      = ce_q;
   assign load    = load_q;
   assign running = running_q;
   assign done    = done_q;

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Control stage directly upstream of the down-counting digit cascade (mod-6 / mod-10 counters chained through CE/CEO).
- Debounces two raw pushbuttons and runs an IDLE/RUN/PAUSE/DONE state machine.
- Prescales clk into a one-cycle count-enable pulse that drives the cascade's CE.
- Issues a load pulse to the cascade's reset input, and stops counting when the cascade reports terminal count (all digits zero).

Parameters:
- PRESCALE, 50_000_000, clk cycles per CE tick; must be >= 2.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable synchronized cycles needed to accept a button level change; must be >= 1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- btn_start  in  1  raw asynchronous pushbutton; each press toggles run/pause.
- btn_clear  in  1  raw asynchronous pushbutton; each press returns the block to IDLE and reloads the cascade.
- tc  in  1  terminal count from the cascade; high when all digits are 0.
- CE  out  1  one-cycle count enable to the least-significant cascade stage.
- load  out  1  one-cycle pulse to the cascade's reset input (reload initial value).
- running  out  1  high in RUN.
- done  out  1  high in DONE.

Behaviour:
- Reset values (reset low, immediate): CE=0, running=0, done=0, load=1, state=IDLE, prescaler=0, debounced levels=0, debounce counters=0.
- load=1 at reset means the cascade is loaded on the first clk edge after reset releases; load then returns to 0.
- All outputs are registered. There is no combinational path from any input to any output.

Button path (identical for each button):
- 2-flop synchronizer.
- Debounce counter increments while the synchronized level differs from the debounced level, and clears when they are equal.
- When the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level takes the new value and the counter clears.
- A rising edge of the debounced level gives a one-cycle press pulse. Releases produce no pulse.

Prescaler:
- Counts 0..PRESCALE-1, advancing only in RUN. tick=1 when the count is PRESCALE-1; the count then wraps to 0.
- Held (not cleared) in PAUSE, so the partial period is preserved.
- Cleared to 0 on clear_press and on the IDLE->RUN transition.
- CE is registered from (state==RUN && tick && !tc). Latency: CE rises one cycle after tick. CE is never asserted while tc=1.

FSM (clear_press has priority over start_press in the same cycle):
- IDLE:
  - start_press && !tc -> RUN.
  - start_press && tc -> stay in IDLE (nothing to count).
- RUN:
  - start_press -> PAUSE.
  - tc==1 -> DONE. If tc and start_press occur in the same cycle, tc wins and the next state is DONE.
- PAUSE:
  - start_press -> RUN (prescaler resumes from its held value).
  - tc is ignored.
- DONE:
  - start_press is ignored.
  - Only clear leaves DONE.
- Any state:
  - clear_press -> IDLE; load=1 for exactly one cycle; prescaler cleared.
- Outputs: running=(next state==RUN) and done=(next state==DONE), both registered, so they track the state with zero added lag.
- Reset asserted mid-operation: all state and outputs return to reset values immediately, independent of clk.

Decomposition:
- Shared package timer_pkg holds:
  - state encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3;
  - default PRESCALE and DEBOUNCE_CYCLES constants;
  - a width-helper function (ceil log2) used to size the prescaler and debounce counters.
- One sub-module, btn_debounce (synchronizer + debounce counter + press-pulse output), instantiated twice.
- The FSM and prescaler stay in timer_ctrl.

Test Plan (PRESCALE=4, DEBOUNCE_CYCLES=3):
1. Hold reset low for 3 cycles, with buttons toggling -> CE=0, running=0, done=0, load=1 throughout. Release -> load=1 through the first edge, then 0; state stays IDLE.
2. tc=0; btn_start high for 8 cycles -> exactly one press. running=1 at 2 sync + 3 debounce cycles + 1 after btn_start rises. CE is then a 1-cycle pulse every 4 cycles, with the first pulse 4 cycles after running rises.
3. btn_start high for 2 cycles (glitch), plus a 1-cycle low notch inside a long press -> no state change from the glitch, and no second press pulse from the notch.
4. Press start in RUN when the prescaler is at 2 -> running=0, no CE. Press again -> first CE arrives after the 1 remaining prescaler count plus the CE register stage. Verify no extra and no lost tick.
5. Raise tc in RUN on the same cycle tick fires -> CE stays 0, done=1 next cycle, running=0. Further start presses are ignored. Clear press -> load=1 for 1 cycle, done=0, IDLE.
6. Start and clear presses resolved on the same cycle in RUN -> IDLE with one load pulse. Then pull reset low mid-RUN between clk edges -> CE/running/done drop to 0 and load goes to 1 asynchronously.
